// File: rtl/jts16b_sndcmd.sv
// -----------------------------------------------------------------------------
// jts16b_sndcmd
// Sound-command consumer for the 315-5195 mapper sound channel.
//
// The 68000 posts a byte through the mapper latch (map_dout / map_obf). This
// block drains each posted byte into a small FIFO and returns a one-clock
// map_rd pulse so the mapper clears OBF. While the FIFO is full it withholds
// map_rd, so OBF stays high and the 68000 sees the buffer as busy. The Z80
// reads commands through an I/O port and sees a level interrupt while any
// command is pending.
//
// Ports
//   clk       in   system clock, single domain
//   rst       in   synchronous active-high reset
//   map_dout  in   [7:0] mapper sound latch value
//   map_obf   in   mapper output-buffer-full flag
//   map_rd    out  one-clock "latch consumed" pulse back to the mapper
//   z80_cs    in   Z80 I/O access to this port
//   z80_rd    in   Z80 read strobe (one clock, qualified by z80_cs)
//   z80_a0    in   0: command data, 1: status
//   z80_dout  out  [7:0] registered read data, held between reads
//   z80_intn  out  Z80 /INT, active low, level while FIFO not empty
//   st_addr   in   [1:0] debug status select
//   st_dout   out  [7:0] registered debug status
// -----------------------------------------------------------------------------
module jts16b_sndcmd #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] map_dout,
    input  logic       map_obf,
    output logic       map_rd,
    input  logic       z80_cs,
    input  logic       z80_rd,
    input  logic       z80_a0,
    output logic [7:0] z80_dout,
    output logic       z80_intn,
    input  logic [1:0] st_addr,
    output logic [7:0] st_dout
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WAITLO = 1'b1
    } state_t;

    // Count shown on the Z80 status port: 4 bits, saturating.
    function automatic logic [3:0] cnt_sat4(input logic [AW:0] c);
        logic [31:0] w;
        w = 32'(c);
        if (w > 32'd15) begin
            cnt_sat4 = 4'hF;
        end else begin
            cnt_sat4 = w[3:0];
        end
    endfunction

    // Count shown on the debug port: 8 bits, saturating.
    function automatic logic [7:0] cnt_sat8(input logic [AW:0] c);
        logic [31:0] w;
        w = 32'(c);
        if (w > 32'd255) begin
            cnt_sat8 = 8'hFF;
        end else begin
            cnt_sat8 = w[7:0];
        end
    endfunction

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic [7:0]    ovf_cnt_r;
    logic [7:0]    last_cmd_r;
    logic          stall_r;
    logic          map_rd_r;
    logic [7:0]    z80_dout_r;
    logic          z80_intn_r;
    logic [7:0]    st_dout_r;
    state_t        state_r;

    state_t        state_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          rd_data_s;
    logic          rd_stat_s;
    logic          stall_s;
    logic [AW:0]   cnt_nxt_s;
    logic [7:0]    status_s;

    assign full_s    = (cnt_r == DEPTH_C);
    assign empty_s   = (cnt_r == (AW + 1)'(0));
    assign rd_data_s = z80_cs & z80_rd & ~z80_a0;
    assign rd_stat_s = z80_cs & z80_rd &  z80_a0;
    // full is judged on the pre-pop count, so a pop on the same clock as a
    // would-be capture delays that capture by one clock.
    assign push_s    = (state_r == IDLE) & map_obf & ~full_s;
    assign pop_s     = rd_data_s & ~empty_s;
    assign stall_s   = (state_r == IDLE) & map_obf & full_s;
    assign status_s  = {empty_s, full_s, map_obf, 1'b0, cnt_sat4(cnt_r)};

    // Capture FSM next state: WAITLO blocks recapture of the same latch value
    // until the mapper drops OBF.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (push_s) begin
                    state_nxt_s = WAITLO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAITLO: begin
                if (!map_obf) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAITLO;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Occupancy after this clock's push/pop.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (push_s && !pop_s) begin
            cnt_nxt_s = cnt_r + (AW + 1)'(1);
        end else if (!push_s && pop_s) begin
            cnt_nxt_s = cnt_r - (AW + 1)'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // FIFO storage; contents are don't-care until written, pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= map_dout;
        end
    end

    // Control state, pointers, counters and the Z80-facing registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cnt_r      <= '0;
            ovf_cnt_r  <= 8'd0;
            last_cmd_r <= 8'd0;
            stall_r    <= 1'b0;
            map_rd_r   <= 1'b0;
            z80_dout_r <= 8'd0;
            z80_intn_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            map_rd_r   <= push_s;
            z80_intn_r <= (cnt_nxt_s == (AW + 1)'(0));
            stall_r    <= stall_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            // One overflow count per stall episode, not per stalled clock.
            if (stall_s && !stall_r && (ovf_cnt_r != 8'hFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 8'd1;
            end
            if (rd_data_s) begin
                if (!empty_s) begin
                    z80_dout_r <= mem_r[rd_ptr_r];
                    last_cmd_r <= mem_r[rd_ptr_r];
                    rd_ptr_r   <= rd_ptr_r + AW'(1);
                end else begin
                    // Empty: repeat the last command without popping.
                    z80_dout_r <= last_cmd_r;
                end
            end else if (rd_stat_s) begin
                z80_dout_r <= status_s;
            end
        end
    end

    // Debug status mux, registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_dout_r <= 8'd0;
        end else begin
            case (st_addr)
                2'd0:    st_dout_r <= cnt_sat8(cnt_r);
                2'd1:    st_dout_r <= ovf_cnt_r;
                2'd2:    st_dout_r <= last_cmd_r;
                2'd3:    st_dout_r <= {6'd0, (state_r == WAITLO), ~z80_intn_r};
                default: st_dout_r <= 8'd0;
            endcase
        end
    end

    assign map_rd   = map_rd_r;
    assign z80_dout = z80_dout_r;
    assign z80_intn = z80_intn_r;
    assign st_dout  = st_dout_r;

endmodule

// File: tb/tb_jts16b_sndcmd.sv
// -----------------------------------------------------------------------------
// tb_jts16b_sndcmd
// Directed bench for jts16b_sndcmd (AW=2, depth 4). A small mapper model in
// the tick task raises OBF for queued commands and drops it one clock after
// seeing map_rd, the way the 315-5195 does.
// -----------------------------------------------------------------------------
module tb_jts16b_sndcmd;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] map_dout;
    logic       map_obf;
    logic       map_rd;
    logic       z80_cs;
    logic       z80_rd;
    logic       z80_a0;
    logic [7:0] z80_dout;
    logic       z80_intn;
    logic [1:0] st_addr;
    logic [7:0] st_dout;

    int passed = 0;
    int total  = 0;

    // mapper model state
    logic [7:0] post_q [$];
    logic       rd_pend  = 1'b0;
    logic       hold_obf = 1'b0;
    int         rd_cnt   = 0;
    int         rd_base  = 0;
    logic [7:0] v;

    jts16b_sndcmd #(.AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .map_dout (map_dout),
        .map_obf  (map_obf),
        .map_rd   (map_rd),
        .z80_cs   (z80_cs),
        .z80_rd   (z80_rd),
        .z80_a0   (z80_a0),
        .z80_dout (z80_dout),
        .z80_intn (z80_intn),
        .st_addr  (st_addr),
        .st_dout  (st_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock; afterwards outputs are sampled and the mapper model updates.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_pend && !hold_obf) begin
            map_obf = 1'b0;
            rd_pend = 1'b0;
        end else if (!map_obf && (post_q.size() > 0)) begin
            map_dout = post_q.pop_front();
            map_obf  = 1'b1;
        end
        if (map_rd === 1'b1) begin
            rd_pend = 1'b1;
            rd_cnt++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic z80_read(input logic a0, output logic [7:0] d);
        z80_cs = 1'b1; z80_rd = 1'b1; z80_a0 = a0;
        tick();
        z80_cs = 1'b0; z80_rd = 1'b0; z80_a0 = 1'b0;
        d = z80_dout;
    endtask

    task automatic get_st(input logic [1:0] a, output logic [7:0] d);
        st_addr = a;
        tick();
        d = st_dout;
    endtask

    initial begin
        rst = 1'b1; map_dout = 8'd0; map_obf = 1'b0;
        z80_cs = 1'b0; z80_rd = 1'b0; z80_a0 = 1'b0; st_addr = 2'd0;
        ticks(2);
        chk("rst_map_rd",   {7'd0, map_rd},   8'd0);
        chk("rst_intn",     {7'd0, z80_intn}, 8'd1);
        chk("rst_z80_dout", z80_dout,         8'h00);
        chk("rst_st_dout",  st_dout,          8'h00);
        rst = 1'b0;

        // 1: single command capture
        rd_base = rd_cnt;
        post_q.push_back(8'h5A);
        ticks(4);
        chk("t1_map_rd_pulses", 8'(rd_cnt - rd_base), 8'd1);
        chk("t1_intn", {7'd0, z80_intn}, 8'd0);
        get_st(2'd0, v); chk("t1_cnt", v, 8'd1);

        // 2: data read then repeat read from empty
        z80_read(1'b0, v); chk("t2_rd1", v, 8'h5A);
        chk("t2_intn", {7'd0, z80_intn}, 8'd1);
        z80_read(1'b0, v); chk("t2_rd2_repeat", v, 8'h5A);
        get_st(2'd0, v); chk("t2_cnt", v, 8'd0);

        // 3: five commands into a four-deep FIFO
        rd_base = rd_cnt;
        for (int i = 1; i <= 5; i++) post_q.push_back(8'(i));
        ticks(30);
        chk("t3_map_rd_pulses", 8'(rd_cnt - rd_base), 8'd4);
        chk("t3_obf_held", {7'd0, map_obf}, 8'd1);
        get_st(2'd0, v); chk("t3_cnt", v, 8'd4);
        get_st(2'd1, v); chk("t3_ovf_cnt", v, 8'd1);
        get_st(2'd3, v); chk("t3_st3", v, 8'h01);
        z80_read(1'b1, v); chk("t3_status", v, 8'b0110_0100);
        ticks(3);
        get_st(2'd1, v); chk("t3_ovf_once", v, 8'd1);

        // 4: one read frees a slot; 05 captured the clock after
        z80_read(1'b0, v); chk("t4_rd01", v, 8'h01);
        tick();
        chk("t4_map_rd_after_pop", {7'd0, map_rd}, 8'd1);
        z80_read(1'b0, v); chk("t4_rd02", v, 8'h02);
        z80_read(1'b0, v); chk("t4_rd03", v, 8'h03);
        z80_read(1'b0, v); chk("t4_rd04", v, 8'h04);
        z80_read(1'b0, v); chk("t4_rd05", v, 8'h05);
        chk("t4_intn", {7'd0, z80_intn}, 8'd1);
        ticks(4);

        // 5: simultaneous pop and capture at cnt=2, write pointer wraps 3->0
        post_q.push_back(8'hA1);
        post_q.push_back(8'hA2);
        ticks(12);
        get_st(2'd0, v); chk("t5_cnt_pre", v, 8'd2);
        post_q.push_back(8'hA3);
        tick();
        z80_read(1'b0, v); chk("t5_rdA1", v, 8'hA1);
        chk("t5_map_rd_same_clk", {7'd0, map_rd}, 8'd1);
        ticks(4);
        get_st(2'd0, v); chk("t5_cnt_same", v, 8'd2);
        post_q.push_back(8'hA4);
        ticks(6);
        get_st(2'd0, v); chk("t5_cnt_3", v, 8'd3);
        z80_read(1'b0, v); chk("t5_rdA2", v, 8'hA2);
        z80_read(1'b0, v); chk("t5_rdA3", v, 8'hA3);
        z80_read(1'b0, v); chk("t5_rdA4", v, 8'hA4);
        ticks(4);

        // 6: reset while in WAITLO with OBF held high
        st_addr  = 2'd2;
        hold_obf = 1'b1;
        post_q.push_back(8'hB1);
        ticks(2);
        chk("t6_captured", {7'd0, map_rd}, 8'd1);
        rst = 1'b1;
        tick();
        chk("t6_rst_map_rd", {7'd0, map_rd},   8'd0);
        chk("t6_rst_intn",   {7'd0, z80_intn}, 8'd1);
        chk("t6_rst_dout",   z80_dout,         8'h00);
        chk("t6_rst_st",     st_dout,          8'h00);
        rd_pend = 1'b0;
        rst = 1'b0;
        tick();
        chk("t6_recapture", {7'd0, map_rd}, 8'd1);
        hold_obf = 1'b0;
        ticks(3);
        get_st(2'd0, v); chk("t6_cnt", v, 8'd1);
        get_st(2'd1, v); chk("t6_ovf_cleared", v, 8'd0);
        z80_read(1'b0, v); chk("t6_rdB1", v, 8'hB1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
